img_data_unpkt: RTL and testbench
=================================

Name: img_data_unpkt

Overview:
- Receive-side counterpart of the image packetiser. Takes 32-bit words from the UDP receiver and rebuilds a raw RGB565 pixel stream for the SDRAM write port, so frames sent from the PC can be written into the frame buffer.
- Finds the frame-header word, splits each word into two pixels, counts pixels against the frame size, and flags malformed or short frames.
- Runs entirely in the eth_rx_clk domain. The SDRAM write FIFO handles the clock crossing.

Parameters:
- CMOS_H_PIXEL, 640, pixels per line.
- CMOS_V_PIXEL, 480, lines per frame.
- FRAME_HEAD, 32'hF05A_A50F, frame-start marker word.
- PCW, $clog2(CMOS_H_PIXEL*CMOS_V_PIXEL+1) = 19, pixel counter width.

Ports:
- clk  in  1  eth_rx_clk; the only clock.
- rst  in  1  synchronous reset, active-high.
- rx_enable  in  1  1 = accept data; 0 = discard words and hold in WAIT_HDR (driven by sys_init_done).
- rec_en  in  1  rec_data valid for one cycle.
- rec_data  in  32  payload word; byte 0 of the payload is in [31:24].
- rec_pkt_done  in  1  one-cycle pulse at end of a UDP packet.
- rec_byte_num  in  16  payload byte count, valid with rec_pkt_done.
- err_clr  in  1  clears err_flags.
- pix_wr_en  out  1  pixel valid; connects to the SDRAM wr_en.
- pix_wr_data  out  16  RGB565 pixel.
- frame_start  out  1  one-cycle pulse when a header is accepted.
- frame_done  out  1  one-cycle pulse together with the last pixel of a frame.
- pix_cnt  out  PCW  pixels emitted in the current frame.
- err_flags  out  4  sticky: [0] short frame, [1] long/excess data, [2] length not a multiple of 4, [3] rec_en spacing violation.

Behaviour:
- Reset values: all outputs 0, state WAIT_HDR, first_word = 1, half-word buffer empty.
- first_word:
  - set by reset and by rec_pkt_done; cleared by any accepted rec_en.
  - If rec_en and rec_pkt_done are asserted in the same cycle, the word belongs to the ending packet and first_word is 1 afterwards.
- State WAIT_HDR:
  - rec_en with first_word = 1, rec_data == FRAME_HEAD and rx_enable = 1 → frame_start = 1 next cycle, pix_cnt := 0, go to FRAME. The header word produces no pixels.
  - Any other word is discarded silently.
- State FRAME:
  - Each accepted word at cycle N gives pix_wr_en = 1 at N+1 with rec_data[31:16] and at N+2 with rec_data[15:0].
  - pix_cnt increments with each emitted pixel.
  - The low half is held in a one-entry buffer.
- rec_en spacing:
  - The source guarantees at least 2 cycles between rec_en pulses (MII gives 8).
  - If rec_en arrives while the buffer is still full: the new word is dropped, err_flags[3] is set, and the buffered pixel is still emitted.
- End of frame:
  - When the emitted pixel is number CMOS_H_PIXEL*CMOS_V_PIXEL, frame_done pulses in the same cycle as that pixel.
  - pix_cnt then returns to 0 and the state goes to WAIT_HDR.
  - If the frame ends on the high half of a word, the low half is discarded and err_flags[1] is set.
- New header mid-frame:
  - A first word equal to FRAME_HEAD while in FRAME and pix_cnt < frame size sets err_flags[0].
  - The frame restarts: frame_start pulses, pix_cnt := 0, any buffered half is discarded.
- Non-header first word in FRAME is treated as pixel data (continuation packet).
- Words arriving in WAIT_HDR after a completed frame (excess data in the same packet) set err_flags[1] and are discarded.
- Length check: rec_pkt_done with rec_byte_num[1:0] != 0 sets err_flags[2]. The data already emitted is kept.
- rx_enable:
  - Deasserting it in any state → WAIT_HDR next cycle; the buffer is cleared and no frame_done is issued.
  - A pixel already registered still completes its output cycle.
- Error flags:
  - err_clr has priority over a set in the same cycle.
  - Flags are otherwise sticky until rst.
- rst asserted mid-frame → all state returns to reset values next cycle and no partial pulses are issued.
- pix_wr_en is never high in two cycles for the same half-word. The maximum output rate is 1 pixel per cycle.

Test Plan:
- Nominal frame at reduced size (H=4, V=2, set by parameter override): header word followed by 4 words 0x11112222…0x77778888, 8 cycles apart → frame_start once; 8 pixel pulses in order 0x1111, 0x2222, …, 0x8888; frame_done with 0x8888; pix_cnt ends at 0; err_flags = 0.
- Multi-packet frame: header plus 2 words, rec_pkt_done, then 2 non-header words in the next packet → 8 pixels, one frame_done; the second packet is not treated as needing a header.
- Short frame: header, 2 words, then a new packet starting with FRAME_HEAD → err_flags[0] = 1, second frame_start, pix_cnt reset to 0; the following full frame completes normally.
- Excess data: header plus 5 words in one packet → frame_done after pixel 8; 5th word dropped; err_flags[1] = 1. Length 22 at rec_pkt_done → err_flags[2] = 1. err_clr → all flags 0.
- Back-to-back rec_en (spacing 1) → second word dropped, err_flags[3] = 1, first word's two pixels still emitted.
- Reset and enable: rst pulse after pixel 3 → outputs 0 next cycle and no frame_done. rx_enable = 0 during a header → no frame_start and no pixels. Simultaneous rec_en and rec_pkt_done → the next word is treated as a first word (header detection works).

Source files
------------

// File: rtl/img_data_unpkt.sv
// Receive-side image unpacker: finds the frame header in 32-bit UDP payload words
// and splits each following word into two RGB565 pixels for the SDRAM write port.
module img_data_unpkt #(
    parameter int          CMOS_H_PIXEL = 640,
    parameter int          CMOS_V_PIXEL = 480,
    parameter logic [31:0] FRAME_HEAD   = 32'hF05A_A50F,
    parameter int          PCW          = $clog2(CMOS_H_PIXEL*CMOS_V_PIXEL+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_enable,
    input  logic           rec_en,
    input  logic [31:0]    rec_data,
    input  logic           rec_pkt_done,
    input  logic [15:0]    rec_byte_num,
    input  logic           err_clr,
    output logic           pix_wr_en,
    output logic [15:0]    pix_wr_data,
    output logic           frame_start,
    output logic           frame_done,
    output logic [PCW-1:0] pix_cnt,
    output logic [3:0]     err_flags
);

    localparam logic [PCW-1:0] FRAME_PIX = PCW'(CMOS_H_PIXEL*CMOS_V_PIXEL);

    typedef enum logic {WAIT_HDR, FRAME} state_t;

    state_t         state_q, state_d;
    logic           first_word_q, first_word_d;
    logic           buf_full_q, buf_full_d;
    logic [15:0]    buf_q, buf_d;
    logic           done_in_pkt_q, done_in_pkt_d;
    logic           pix_wr_en_q, pix_wr_en_d;
    logic [15:0]    pix_wr_data_q, pix_wr_data_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_done_q, frame_done_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    logic [3:0]     err_q, err_d;
    logic [3:0]     err_set;
    logic           is_head;
    logic [PCW-1:0] cnt_inc;

    assign is_head = rec_en && first_word_q && (rec_data == FRAME_HEAD);
    assign cnt_inc = pix_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_HDR;
            first_word_q  <= 1'b1;
            buf_full_q    <= 1'b0;
            buf_q         <= '0;
            done_in_pkt_q <= 1'b0;
            pix_wr_en_q   <= 1'b0;
            pix_wr_data_q <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            pix_cnt_q     <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            first_word_q  <= first_word_d;
            buf_full_q    <= buf_full_d;
            buf_q         <= buf_d;
            done_in_pkt_q <= done_in_pkt_d;
            pix_wr_en_q   <= pix_wr_en_d;
            pix_wr_data_q <= pix_wr_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            pix_cnt_q     <= pix_cnt_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        first_word_d  = first_word_q;
        buf_full_d    = buf_full_q;
        buf_d         = buf_q;
        done_in_pkt_d = done_in_pkt_q;
        pix_wr_en_d   = 1'b0;
        pix_wr_data_d = pix_wr_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        pix_cnt_d     = pix_cnt_q;
        err_set       = '0;

        // A word arriving with rec_pkt_done still belongs to the ending packet.
        if (rec_en) first_word_d = 1'b0;
        if (rec_pkt_done) begin
            first_word_d  = 1'b1;
            done_in_pkt_d = 1'b0;
            if (rec_byte_num[1:0] != 2'b00) err_set[2] = 1'b1;
        end

        if (!rx_enable) begin
            state_d       = WAIT_HDR;
            buf_full_d    = 1'b0;
            pix_cnt_d     = '0;
            done_in_pkt_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_HDR: begin
                    pix_cnt_d = '0;
                    if (is_head) begin
                        state_d       = FRAME;
                        frame_start_d = 1'b1;
                        done_in_pkt_d = 1'b0;
                    end else if (rec_en && done_in_pkt_q) begin
                        err_set[1] = 1'b1;
                    end
                end
                FRAME: begin
                    // Buffered low half goes out first; a word arriving now is dropped.
                    if (buf_full_q) begin
                        pix_wr_en_d   = 1'b1;
                        pix_wr_data_d = buf_q;
                        buf_full_d    = 1'b0;
                        pix_cnt_d     = cnt_inc;
                        if (rec_en) err_set[3] = 1'b1;
                        if (cnt_inc == FRAME_PIX) begin
                            frame_done_d  = 1'b1;
                            state_d       = WAIT_HDR;
                            done_in_pkt_d = !rec_pkt_done;
                        end
                    end else if (is_head) begin
                        if (pix_cnt_q < FRAME_PIX) err_set[0] = 1'b1;
                        frame_start_d = 1'b1;
                        pix_cnt_d     = '0;
                    end else if (rec_en) begin
                        pix_wr_en_d   = 1'b1;
                        pix_wr_data_d = rec_data[31:16];
                        pix_cnt_d     = cnt_inc;
                        if (cnt_inc == FRAME_PIX) begin
                            frame_done_d  = 1'b1;
                            state_d       = WAIT_HDR;
                            done_in_pkt_d = !rec_pkt_done;
                            err_set[1]    = 1'b1;
                        end else begin
                            buf_d      = rec_data[15:0];
                            buf_full_d = 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_HDR;
            endcase
        end

        err_d = err_clr ? '0 : (err_q | err_set);
    end

    assign pix_wr_en   = pix_wr_en_q;
    assign pix_wr_data = pix_wr_data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign pix_cnt     = pix_cnt_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_img_data_unpkt.sv
// Directed bench for img_data_unpkt at a 4x2 frame: cycle vector table plus
// hand-written multi-cycle sequences for restart, excess, spacing, reset and enable.
module tb_img_data_unpkt;

    localparam logic [31:0] HEAD = 32'hF05A_A50F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_enable = 1'b0;
    logic        rec_en = 1'b0;
    logic [31:0] rec_data = '0;
    logic        rec_pkt_done = 1'b0;
    logic [15:0] rec_byte_num = '0;
    logic        err_clr = 1'b0;
    logic        pix_wr_en;
    logic [15:0] pix_wr_data;
    logic        frame_start;
    logic        frame_done;
    logic [3:0]  pix_cnt;
    logic [3:0]  err_flags;

    img_data_unpkt #(.CMOS_H_PIXEL(4), .CMOS_V_PIXEL(2)) dut (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rec_en(rec_en),
        .rec_data(rec_data), .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
        .err_clr(err_clr), .pix_wr_en(pix_wr_en), .pix_wr_data(pix_wr_data),
        .frame_start(frame_start), .frame_done(frame_done), .pix_cnt(pix_cnt),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [31:0] d;
        logic        pd;
        logic [15:0] bn;
        logic        we;
        logic [15:0] wd;
        logic        fs;
        logic        fd;
        logic [3:0]  cnt;
        logic [3:0]  err;
    } vec_t;

    vec_t        vt[$];
    logic [15:0] pix_q[$];
    logic [31:0] words[5];
    logic [15:0] exp_pix[8];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned fs_cnt = 0;
    int unsigned fd_cnt = 0;
    logic [15:0] fd_data = '0;
    logic        fd_we = 1'b0;

    function automatic vec_t mk(logic en, logic [31:0] d, logic pd, logic [15:0] bn,
                                logic we, logic [15:0] wd, logic fs, logic fd,
                                logic [3:0] cnt, logic [3:0] err);
        vec_t v;
        v = '{en, d, pd, bn, we, wd, fs, fd, cnt, err};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pix_wr_en) pix_q.push_back(pix_wr_data);
        if (frame_start) fs_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_data = pix_wr_data;
            fd_we   = pix_wr_en;
        end
    endtask

    task automatic clear_mon();
        pix_q.delete();
        fs_cnt = 0;
        fd_cnt = 0;
        fd_data = '0;
        fd_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic send(input logic [31:0] w, input int unsigned gap);
        rec_en   = 1'b1;
        rec_data = w;
        step();
        rec_en = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic pkt_end(input logic [15:0] bn);
        rec_pkt_done = 1'b1;
        rec_byte_num = bn;
        step();
        rec_pkt_done = 1'b0;
        step();
    endtask

    task automatic chk_pix(input string name, input int unsigned n);
        chk({name, " count"}, pix_q.size(), n);
        for (int i = 0; i < int'(n) && i < pix_q.size(); i++)
            chk($sformatf("%s pix%0d", name, i), pix_q[i], exp_pix[i]);
    endtask

    initial begin
        words[0] = 32'h1111_2222;
        words[1] = 32'h3333_4444;
        words[2] = 32'h5555_6666;
        words[3] = 32'h7777_8888;
        words[4] = 32'h9999_AAAA;
        exp_pix = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                    16'h5555, 16'h6666, 16'h7777, 16'h8888};

        // Per-cycle vectors: nominal frame with the minimum 2-cycle word spacing.
        vt.push_back(mk(1, HEAD,     0, 0,  0, 16'h0000, 1, 0, 0, 0));
        vt.push_back(mk(0, 0,        0, 0,  0, 16'h0000, 0, 0, 0, 0));
        vt.push_back(mk(1, words[0], 0, 0,  1, 16'h1111, 0, 0, 1, 0));
        vt.push_back(mk(0, 0,        0, 0,  1, 16'h2222, 0, 0, 2, 0));
        vt.push_back(mk(1, words[1], 0, 0,  1, 16'h3333, 0, 0, 3, 0));
        vt.push_back(mk(0, 0,        0, 0,  1, 16'h4444, 0, 0, 4, 0));
        vt.push_back(mk(1, words[2], 0, 0,  1, 16'h5555, 0, 0, 5, 0));
        vt.push_back(mk(0, 0,        0, 0,  1, 16'h6666, 0, 0, 6, 0));
        vt.push_back(mk(1, words[3], 0, 0,  1, 16'h7777, 0, 0, 7, 0));
        vt.push_back(mk(0, 0,        0, 0,  1, 16'h8888, 0, 1, 8, 0));
        vt.push_back(mk(0, 0,        1, 20, 0, 16'h0000, 0, 0, 0, 0));

        // Reset state
        step();
        chk("reset outputs", {pix_wr_en, pix_wr_data, frame_start, frame_done, pix_cnt, err_flags}, '0);
        rst = 1'b0;
        rx_enable = 1'b1;
        clear_mon();

        foreach (vt[i]) begin
            rec_en       = vt[i].en;
            rec_data     = vt[i].d;
            rec_pkt_done = vt[i].pd;
            rec_byte_num = vt[i].bn;
            step();
            if (vt[i].we || vt[i].fd)
                chk($sformatf("vec%0d", i),
                    {pix_wr_en, pix_wr_data, frame_start, frame_done, pix_cnt, err_flags},
                    {vt[i].we, vt[i].wd, vt[i].fs, vt[i].fd, vt[i].cnt, vt[i].err});
            else
                chk($sformatf("vec%0d", i),
                    {pix_wr_en, frame_start, frame_done, pix_cnt, err_flags},
                    {vt[i].we, vt[i].fs, vt[i].fd, vt[i].cnt, vt[i].err});
        end
        rec_en = 1'b0;
        rec_pkt_done = 1'b0;

        // Nominal frame, words 8 cycles apart
        do_reset();
        send(HEAD, 8);
        for (int i = 0; i < 4; i++) send(words[i], 8);
        pkt_end(16'd20);
        chk_pix("nominal", 8);
        chk("nominal fs", fs_cnt, 1);
        chk("nominal fd", fd_cnt, 1);
        chk("nominal fd pix", {fd_we, fd_data}, {1'b1, 16'h8888});
        chk("nominal cnt", pix_cnt, 0);
        chk("nominal err", err_flags, 0);

        // Frame spread over two packets
        clear_mon();
        send(HEAD, 8);
        send(words[0], 8);
        send(words[1], 8);
        pkt_end(16'd12);
        send(words[2], 8);
        send(words[3], 8);
        pkt_end(16'd8);
        chk_pix("multipkt", 8);
        chk("multipkt fs", fs_cnt, 1);
        chk("multipkt fd", fd_cnt, 1);
        chk("multipkt err", err_flags, 0);

        // Short frame restarted by a new header
        clear_mon();
        send(HEAD, 8);
        send(words[0], 8);
        send(words[1], 8);
        pkt_end(16'd12);
        rec_en = 1'b1;
        rec_data = HEAD;
        step();
        rec_en = 1'b0;
        chk("restart", {frame_start, pix_cnt, err_flags}, {1'b1, 4'd0, 4'b0001});
        repeat (7) step();
        chk("restart fs", fs_cnt, 2);
        clear_mon();
        for (int i = 0; i < 4; i++) send(words[i], 8);
        pkt_end(16'd20);
        chk_pix("after restart", 8);
        chk("after restart fd", fd_cnt, 1);
        chk("after restart err", err_flags, 4'b0001);

        // Excess data, odd length, err_clr
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr1", err_flags, 0);
        clear_mon();
        send(HEAD, 8);
        for (int i = 0; i < 5; i++) send(words[i], 8);
        pkt_end(16'd22);
        chk_pix("excess", 8);
        chk("excess fd", fd_cnt, 1);
        chk("excess err", err_flags, 4'b0110);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr2", err_flags, 0);

        // Back-to-back rec_en
        do_reset();
        send(HEAD, 8);
        send(words[0], 1);
        send(words[1], 8);
        chk_pix("b2b", 2);
        chk("b2b err", err_flags, 4'b1000);

        // Reset mid-frame after pixel 3
        do_reset();
        send(HEAD, 8);
        send(words[0], 8);
        rec_en = 1'b1;
        rec_data = words[1];
        step();
        rec_en = 1'b0;
        chk("pix3 cnt", pix_cnt, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst outputs", {pix_wr_en, frame_start, frame_done, pix_cnt, err_flags}, '0);
        send(words[2], 8);
        chk_pix("midrst", 3);
        chk("midrst fd", fd_cnt, 0);

        // rx_enable low during header, then dropped mid-frame
        do_reset();
        rx_enable = 1'b0;
        send(HEAD, 8);
        chk("disabled fs", fs_cnt, 0);
        chk("disabled pix", pix_q.size(), 0);
        pkt_end(16'd4);
        rx_enable = 1'b1;
        send(HEAD, 8);
        send(words[0], 8);
        send(words[1], 8);
        rec_en = 1'b1;
        rec_data = words[2];
        step();
        rec_en = 1'b0;
        rx_enable = 1'b0;
        repeat (4) step();
        rx_enable = 1'b1;
        send(words[3], 8);
        chk_pix("rxen drop", 5);
        chk("rxen drop fd", fd_cnt, 0);
        chk("rxen drop err", err_flags, 0);
        pkt_end(16'd20);

        // rec_en together with rec_pkt_done keeps the next word a first word
        do_reset();
        rec_en = 1'b1;
        rec_data = 32'hDEAD_BEEF;
        rec_pkt_done = 1'b1;
        rec_byte_num = 16'd4;
        step();
        rec_en = 1'b0;
        rec_pkt_done = 1'b0;
        step();
        send(HEAD, 4);
        chk("sim done fs", fs_cnt, 1);
        chk("sim done err", err_flags, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
